// File: rtl/phase_sweep_nco.sv
// Phase-angle generator: fixed-frequency ramp or linear chirp, one angle per clock,
// run as a burst of programmed length or continuously until stopped.
module phase_sweep_nco #(
   parameter int WIDTH = 16,
   parameter int FW    = 24,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [FW-1:0]    cfg_fcw,
   input  logic [FW-1:0]    cfg_step,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             done,
   output logic             angle_valid,
   output logic [WIDTH-1:0] ANGLE,
   output logic             wrap
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q;
   logic [FW-1:0]      fcw_q, step_q, acc_q, fcwCur_q;
   logic [CNT_W-1:0]   len_q, cnt_q;
   logic               cont_q, carry_q, done_q, angleValid_q, wrap_q;
   logic [WIDTH-1:0]   angle_q;

   logic [FW:0]        sum_d;
   logic [FW-1:0]      fcwSel_d;
   logic [CNT_W-1:0]   lenSel_d;

   // A config offered in the same cycle as start takes effect for that run.
   always_comb begin
      sum_d    = {1'b0, acc_q} + {1'b0, fcwCur_q};
      fcwSel_d = cfg_valid ? cfg_fcw : fcw_q;
      lenSel_d = cfg_valid ? cfg_len : len_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         fcw_q        <= '0;
         step_q       <= '0;
         len_q        <= '0;
         acc_q        <= '0;
         fcwCur_q     <= '0;
         cnt_q        <= '0;
         cont_q       <= 1'b0;
         carry_q      <= 1'b0;
         done_q       <= 1'b0;
         angleValid_q <= 1'b0;
         wrap_q       <= 1'b0;
         angle_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cfg_valid) begin
                  fcw_q  <= cfg_fcw;
                  step_q <= cfg_step;
                  len_q  <= cfg_len;
               end
               if (start) begin
                  acc_q    <= '0;
                  fcwCur_q <= fcwSel_d;
                  cnt_q    <= lenSel_d;
                  cont_q   <= (lenSel_d == '0);
                  carry_q  <= 1'b0;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               // Stop takes priority, even over the end of a complete burst.
               if (stop) begin
                  state_q      <= IDLE;
                  angleValid_q <= 1'b0;
                  wrap_q       <= 1'b0;
               end else if (!cont_q && cnt_q == '0) begin
                  state_q      <= DONE;
                  done_q       <= 1'b1;
                  angleValid_q <= 1'b0;
                  wrap_q       <= 1'b0;
               end else begin
                  angle_q      <= acc_q[FW-1 -: WIDTH];
                  angleValid_q <= 1'b1;
                  wrap_q       <= carry_q;
                  acc_q        <= sum_d[FW-1:0];
                  carry_q      <= sum_d[FW];
                  fcwCur_q     <= fcwCur_q + step_q;
                  if (!cont_q) begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cfg_ready   = (state_q == IDLE);
   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign angle_valid = angleValid_q;
   assign ANGLE       = angle_q;
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_phase_sweep_nco.sv
// Directed plus randomized bench for phase_sweep_nco; expected angles come from the
// closed-form phase n*fcw + n(n-1)/2*step rather than from stepping an accumulator.
module tb_phase_sweep_nco;

   localparam int WIDTH = 16;
   localparam int FW    = 24;
   localparam int CNT_W = 16;
   localparam longint unsigned MOD = 64'd1 << FW;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [FW-1:0]    cfg_fcw = '0;
   logic [FW-1:0]    cfg_step = '0;
   logic [CNT_W-1:0] cfg_len = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             busy, done, angle_valid, wrap;
   logic [WIDTH-1:0] ANGLE;

   int checks = 0;
   int failures = 0;

   phase_sweep_nco #(.WIDTH(WIDTH), .FW(FW), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_fcw(cfg_fcw), .cfg_step(cfg_step), .cfg_len(cfg_len),
      .start(start), .stop(stop),
      .busy(busy), .done(done), .angle_valid(angle_valid),
      .ANGLE(ANGLE), .wrap(wrap)
   );

   always #5 CLK = ~CLK;

   // Sample phase of sample n, straight from the closed form.
   function automatic longint unsigned phaseAt(input longint unsigned f, input longint unsigned s,
                                               input longint unsigned n);
      return (n * f + ((n * (n - 1)) / 2) * s) % MOD;
   endfunction

   function automatic longint unsigned fcwAt(input longint unsigned f, input longint unsigned s,
                                             input longint unsigned k);
      return (f + k * s) % MOD;
   endfunction

   function automatic logic [WIDTH-1:0] angleAt(input longint unsigned f, input longint unsigned s,
                                                input longint unsigned n);
      longint unsigned p;
      p = phaseAt(f, s, n) >> (FW - WIDTH);
      return p[WIDTH-1:0];
   endfunction

   // Sample n wraps when the accumulation that produced it overflowed 2^FW.
   function automatic logic wrapAt(input longint unsigned f, input longint unsigned s,
                                   input longint unsigned n);
      if (n == 0) return 1'b0;
      return (phaseAt(f, s, n - 1) + fcwAt(f, s, n - 1)) >= MOD;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [FW-1:0] f, input logic [FW-1:0] s,
                                input logic [CNT_W-1:0] l, input logic st, input logic sp);
      cfg_valid = v;
      cfg_fcw   = f;
      cfg_step  = s;
      cfg_len   = l;
      start     = st;
      stop      = sp;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic expectSamples(input string tag, input logic [FW-1:0] f, input logic [FW-1:0] s,
                                input int first, input int count);
      for (int k = 0; k < count; k++) begin
         int n;
         n = first + k;
         tick();
         checkOutput($sformatf("%s valid[%0d]", tag, n), {31'd0, angle_valid}, 32'd1);
         checkOutput($sformatf("%s angle[%0d]", tag, n), {16'd0, ANGLE}, {16'd0, angleAt(f, s, n)});
         checkOutput($sformatf("%s wrap[%0d]", tag, n), {31'd0, wrap}, {31'd0, wrapAt(f, s, n)});
      end
   endtask

   task automatic expectDone(input string tag, input logic [FW-1:0] f, input logic [FW-1:0] s, input int l);
      tick();
      checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
      checkOutput({tag, " validAtDone"}, {31'd0, angle_valid}, 32'd0);
      checkOutput({tag, " busyAtDone"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " readyAtDone"}, {31'd0, cfg_ready}, 32'd0);
      checkOutput({tag, " angleHeld"}, {16'd0, ANGLE}, {16'd0, angleAt(f, s, l - 1)});
      tick();
      checkOutput({tag, " doneLow"}, {31'd0, done}, 32'd0);
      checkOutput({tag, " readyBack"}, {31'd0, cfg_ready}, 32'd1);
   endtask

   task automatic runBurst(input string tag, input logic [FW-1:0] f, input logic [FW-1:0] s, input int l);
      applyStimulus(1'b1, f, s, l[CNT_W-1:0], 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      tick();
      idleInputs();
      checkOutput({tag, " busyAtStart"}, {31'd0, busy}, 32'd1);
      checkOutput({tag, " validAtStart"}, {31'd0, angle_valid}, 32'd0);
      expectSamples(tag, f, s, 0, l);
      expectDone(tag, f, s, l);
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, " valid"}, {31'd0, angle_valid}, 32'd0);
      checkOutput({tag, " done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " ready"}, {31'd0, cfg_ready}, 32'd1);
   endtask

   initial begin
      logic [FW-1:0] rf, rs;
      int rl;

      idleInputs();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      checkQuiet("reset");
      checkOutput("reset angle", {16'd0, ANGLE}, 32'd0);
      checkOutput("reset wrap", {31'd0, wrap}, 32'd0);

      runBurst("ramp", 24'h010000, 24'h000000, 4);
      runBurst("wrap", 24'h400000, 24'h000000, 6);
      runBurst("chirp", 24'h000100, 24'h000100, 5);
      runBurst("downchirp", 24'h000100, 24'hFFFF00, 5);
      runBurst("len1", 24'h0ABCDE, 24'h000000, 1);

      for (int i = 0; i < 6; i++) begin
         rf = $urandom() & 32'h00FF_FFFF;
         rs = $urandom() & 32'h00FF_FFFF;
         rl = $urandom_range(2, 12);
         $display("[TB] random burst %0d fcw=0x%06h step=0x%06h len=%0d", i, rf, rs, rl);
         runBurst($sformatf("rand%0d", i), rf, rs, rl);
      end

      // Continuous run stopped while the third sample is visible.
      applyStimulus(1'b1, 24'h123456, 24'h000000, '0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      tick();
      idleInputs();
      expectSamples("stopcont", 24'h123456, 24'h000000, 0, 3);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
      tick();
      idleInputs();
      checkQuiet("stopcont after");
      checkOutput("stopcont angleHeld", {16'd0, ANGLE}, {16'd0, angleAt(24'h123456, 0, 2)});
      for (int k = 0; k < 3; k++) begin
         tick();
         checkQuiet($sformatf("stopcont idle%0d", k));
      end

      // Stop coinciding with the last sample of a burst suppresses done.
      applyStimulus(1'b1, 24'h0A0000, 24'h000000, 16'd3, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      tick();
      idleInputs();
      expectSamples("stoplast", 24'h0A0000, 24'h000000, 0, 3);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
      tick();
      idleInputs();
      checkQuiet("stoplast after");
      tick();
      checkQuiet("stoplast later");

      // Config offered and start pulsed mid-run are both ignored.
      applyStimulus(1'b1, 24'h030000, 24'h000010, 16'd6, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      tick();
      idleInputs();
      expectSamples("cfgrun", 24'h030000, 24'h000010, 0, 2);
      applyStimulus(1'b1, 24'h7F0000, 24'h000005, 16'd2, 1'b0, 1'b0);
      checkOutput("cfgrun readyInRun", {31'd0, cfg_ready}, 32'd0);
      expectSamples("cfgrun", 24'h030000, 24'h000010, 2, 1);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      expectSamples("cfgrun", 24'h030000, 24'h000010, 3, 1);
      idleInputs();
      expectSamples("cfgrun", 24'h030000, 24'h000010, 4, 2);
      expectDone("cfgrun", 24'h030000, 24'h000010, 6);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      tick();
      idleInputs();
      expectSamples("cfgkept", 24'h030000, 24'h000010, 0, 6);
      expectDone("cfgkept", 24'h030000, 24'h000010, 6);

      // New config and start in the same cycle: the run uses the new FCW.
      applyStimulus(1'b1, 24'h020000, 24'h000000, 16'd4, 1'b1, 1'b0);
      tick();
      idleInputs();
      checkOutput("samecycle busy", {31'd0, busy}, 32'd1);
      expectSamples("samecycle", 24'h020000, 24'h000000, 0, 4);
      expectDone("samecycle", 24'h020000, 24'h000000, 4);

      // Reset in the middle of a continuous run.
      applyStimulus(1'b1, 24'h010000, 24'h000000, '0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      tick();
      idleInputs();
      expectSamples("rstrun", 24'h010000, 24'h000000, 0, 5);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checkQuiet("rstrun after");
      checkOutput("rstrun angle", {16'd0, ANGLE}, 32'd0);
      checkOutput("rstrun wrap", {31'd0, wrap}, 32'd0);
      tick();
      checkQuiet("rstrun later");

      // Start with config cleared by reset: continuous constant zero.
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      tick();
      idleInputs();
      checkOutput("zero busy", {31'd0, busy}, 32'd1);
      expectSamples("zero", 24'h000000, 24'h000000, 0, 20);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
      tick();
      idleInputs();
      checkQuiet("zero stopped");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phase_sweep_nco.md
# phase_sweep_nco

Phase-angle generator that sits directly upstream of the sine/square-root stage and drives its `A` angle input, one angle per clock. It holds a configurable frequency control word (FCW) and an optional linear FCW increment, so it produces either a fixed-frequency ramp or a linear chirp. Each run is a burst of a programmed length, or it runs continuously until stopped. Configuration uses a valid/ready handshake; runs are started and stopped with single-cycle pulses.

## Interface
- `WIDTH`, 16: output angle width; matches the downstream stage's `width`.
- `FW`, 24: phase accumulator, FCW and step width; must satisfy FW ≥ WIDTH.
- `CNT_W`, 16: burst length counter width.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1: configuration offered.
- `cfg_ready` out 1: configuration accepted this cycle when high.
- `cfg_fcw` in FW: start FCW, unsigned.
- `cfg_step` in FW: per-sample FCW increment, two's complement.
- `cfg_len` in CNT_W: number of samples per burst; 0 means continuous.
- `start` in 1: single-cycle pulse; begins a run.
- `stop` in 1: single-cycle pulse; aborts a run.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse at the end of a complete burst.
- `angle_valid` out 1: `ANGLE` holds a valid sample this cycle.
- `ANGLE` out WIDTH: angle sample, defined as acc[FW-1 -: WIDTH].
- `wrap` out 1: high together with a sample whose accumulation overflowed 2^FW.

## Operation
- States: IDLE, RUN, DONE.
- `cfg_ready` = (state == IDLE).
- Config registers reset to fcw=0, step=0, len=0.
- **IDLE**
  - When `cfg_valid & cfg_ready`, latch fcw, step and len.
  - On `start`: acc←0, fcw_cur←fcw, cnt←len, state←RUN.
  - If `cfg_valid` and `start` arrive in the same cycle, the newly latched config is used for the run.
  - `stop` has no effect in IDLE.
- **RUN**, on each edge:
  - ANGLE←acc[FW-1 -: WIDTH]; angle_valid←1; wrap←carry registered from the previous accumulate.
  - acc←(acc+fcw_cur) mod 2^FW; fcw_cur←(fcw_cur+step) mod 2^FW.
  - If len≠0, cnt decrements; after the len-th sample is emitted, state←DONE.
- **DONE**: one cycle; done=1, angle_valid=0; then state←IDLE.
- `stop` in RUN:
  - state←IDLE on the next edge; angle_valid low from that edge; no done pulse.
  - If `stop` coincides with the last sample, stop wins and done is not pulsed.
- `start` while in RUN or DONE is ignored.
- `cfg_valid` outside IDLE is ignored and not held.
- Sample n (n=0,1,…) has phase n·fcw + n(n−1)/2·step mod 2^FW; sample 0 is always 0.
- The FCW wraps modularly (no saturation); a negative step produces a down-chirp.
- `start` with no config loaded since reset emits constant 0 continuously until `stop`.

## Timing
- `RST` is sampled on the edge. After it:
  - state=IDLE, acc=0, fcw_cur=0, cnt=0.
  - `ANGLE`=0, `angle_valid`=0, `wrap`=0, `busy`=0, `done`=0, `cfg_ready`=1.
- `RST` during RUN aborts the run immediately with the values above; there is no done pulse and the config registers are cleared.
- `start` sampled at edge t: busy=1 from t; the first angle_valid with ANGLE=0 appears after edge t+1; one sample per cycle after that, with no gaps.
- For len=L, the last sample is valid after edge t+L; done is high after edge t+L+1; cfg_ready returns after edge t+L+2.
- `wrap` aligns with the first sample numerically below its predecessor (for positive FCW).
- `ANGLE` holds its last value when angle_valid=0.
- Downstream timing: it registers its own output one cycle after `A`, so total angle-to-result latency is 1 + the downstream latency.

## Test plan
- Reset mid-run:
  - Stimulus: start with fcw=0x010000 and len=0, run 5 samples, then assert RST.
  - Response: the next cycle has all outputs 0, cfg_ready=1, and no done pulse.
- Fixed ramp:
  - Stimulus: fcw=0x010000, step=0, len=4, then start.
  - Response: ANGLE = 0x0000, 0x0100, 0x0200, 0x0300 on consecutive cycles, then done for 1 cycle, then cfg_ready=1.
- Wrap:
  - Stimulus: fcw=0x400000, len=6.
  - Response: ANGLE = 0x0000, 0x4000, 0x8000, 0xC000, 0x0000, 0x4000, with wrap=1 only on the 5th sample.
- Chirp:
  - Stimulus: fcw=0x000100, step=0x000100, len=5.
  - Response: acc = 0x000000, 0x000100, 0x000300, 0x000600, 0x000A00, so ANGLE = 0x0000, 0x0001, 0x0003, 0x0006, 0x000A.
  - Repeat with step=0xFFFF00 (down-chirp) and check the values against the closed form.
- Stop and handshake:
  - Stimulus: start with len=0, then stop after 3 samples.
  - Response: exactly 3 valid samples and no done.
  - Also check: stop on the last sample of len=3 gives no done; cfg_valid during RUN leaves the config unchanged and cfg_ready=0.
- Same-cycle events:
  - Stimulus: in IDLE, cfg_valid with fcw=0x020000 in the same cycle as start.
  - Response: the run uses the new FCW (ANGLE 0x0000, 0x0200, …).
  - Also check: start in RUN is ignored; start straight after reset gives constant ANGLE=0.
